// File: rtl/bcd_pkg.sv
// Shared types, constant functions and width helpers for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Largest digit count the 64-bit weight arithmetic is sized for
  localparam int MAX_DIGITS = 9;

  // 10^k as a 64-bit constant; used for both the weight table and the
  // overflow limit 10^DIGITS
  function automatic logic [63:0] pow10(input int k);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < k; i++) begin
      v = v * 64'd10;
    end
    return v;
  endfunction

  // Ceiling log2: smallest r with 2^r >= n
  function automatic int clog2(input logic [63:0] n);
    int          r;
    logic [63:0] v;
    r = 0;
    v = 64'd1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Width of the decimal weights and of the trial difference
  function automatic int wt_w(input int digits);
    return clog2(pow10(digits)) + 1;
  endfunction

  // Remainder width: one extra bit so the most negative input's magnitude fits
  function automatic int rest_w(input int bin_w);
    return bin_w + 1;
  endfunction

  // Digit pointer width, never narrower than one bit
  function automatic int ptr_w(input int digits);
    return (digits > 1) ? clog2(64'(digits)) : 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/result bundle of the binary-to-BCD converter. The master side
// issues conversions, the slave side (the converter) returns the result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8
);
  logic                  st;
  logic                  sgn;
  logic [BIN_W-1:0]      BIN;
  logic [4*DIGITS-1:0]   DEC;
  logic                  neg;
  logic                  ovf;
  logic [DIGITS-1:0]     lz_mask;
  logic                  busy;
  logic                  done;

  modport master (
    output st, sgn, BIN,
    input  DEC, neg, ovf, lz_mask, busy, done
  );

  modport slave (
    input  st, sgn, BIN,
    output DEC, neg, ovf, lz_mask, busy, done
  );
endinterface

// File: rtl/bcd_pow10_rom.sv
// Combinational decimal-weight lookup: digit pointer -> 10^ptr.
// Kept apart from the FSM so the weight mux is a plain constant table.
module bcd_pow10_rom
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 8,
  parameter  int WT_W   = 28,
  localparam int PTR_W  = ptr_w(DIGITS)
) (
  input  logic [PTR_W-1:0] i_ptr,
  output logic [WT_W-1:0]  o_wt
);

  logic [WT_W-1:0] w_tab [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_tab
    assign w_tab[g] = WT_W'(pow10(g));
  end

  // Select the weight addressed by the pointer
  always_comb begin
    o_wt = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_ptr == PTR_W'(k)) begin
        o_wt = w_tab[k];
      end
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter. Each clock subtracts the current
// decimal weight from the remainder when it fits (incrementing that digit),
// otherwise moves to the next lower digit. Supports two's-complement input,
// overflow flagging and a leading-zero mask for display blanking.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int          WT_W   = wt_w(DIGITS);
  localparam int          REST_W = rest_w(BIN_W);
  localparam int          PTR_W  = ptr_w(DIGITS);
  localparam int          CMP_W  = ((WT_W > REST_W) ? WT_W : REST_W) + 1;
  localparam logic [63:0] LIMIT  = pow10(DIGITS);

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_CONV = 2'(S_CONV);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  logic [1:0]          r_state;
  logic [REST_W-1:0]   r_rest;
  logic [PTR_W-1:0]    r_ptr;
  logic [4*DIGITS-1:0] r_dec;
  logic                r_neg;
  logic                r_ovf;

  logic [REST_W-1:0]   w_bin_ext;
  logic                w_neg;
  logic [REST_W-1:0]   w_mag;
  logic                w_ovf;
  logic [WT_W-1:0]     w_wt;
  logic                w_ge;
  logic [REST_W-1:0]   w_diff;
  logic [4*DIGITS-1:0] w_dec_inc;
  logic [DIGITS-1:0]   w_lz;

  // Input capture path: sign-extend only for signed requests, then take the
  // magnitude one bit wider than BIN so the most negative value survives.
  assign w_bin_ext = bus.sgn ? {bus.BIN[BIN_W-1], bus.BIN} : {1'b0, bus.BIN};
  assign w_neg     = bus.sgn & bus.BIN[BIN_W-1];
  assign w_mag     = w_neg ? (-w_bin_ext) : w_bin_ext;
  assign w_ovf     = (64'(w_mag) >= LIMIT);

  bcd_pow10_rom #(
    .DIGITS (DIGITS),
    .WT_W   (WT_W)
  ) u_rom (
    .i_ptr (r_ptr),
    .o_wt  (w_wt)
  );

  // Trial subtraction: the compare decides, the difference is only taken
  // when the weight fits, so it never needs more than REST_W bits.
  assign w_ge   = (CMP_W'(r_rest) >= CMP_W'(w_wt));
  assign w_diff = r_rest - REST_W'(w_wt);

  // Digit register image with the pointed-at digit bumped by one
  always_comb begin
    w_dec_inc = r_dec;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_ptr == PTR_W'(k)) begin
        w_dec_inc[4*k +: 4] = r_dec[4*k +: 4] + 4'd1;
      end
    end
  end

  // Control FSM with remainder, pointer and digit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rest  <= '0;
      r_ptr   <= '0;
      r_dec   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.st) begin
            r_neg   <= w_neg;
            r_ovf   <= w_ovf;
            r_dec   <= '0;
            r_rest  <= w_mag;
            r_ptr   <= PTR_W'(DIGITS - 1);
            r_state <= w_ovf ? ST_DONE : ST_CONV;
          end
        end
        ST_CONV: begin
          if (w_ge) begin
            r_rest <= w_diff;
            r_dec  <= w_dec_inc;
          end else if (r_ptr != '0) begin
            r_ptr <= r_ptr - PTR_W'(1);
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Leading-zero mask: a digit blanks when it and every digit above are zero;
  // the units digit is always shown.
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_lz   = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      v_zero  = v_zero & (r_dec[4*k +: 4] == 4'd0);
      w_lz[k] = v_zero;
    end
  end

  assign bus.DEC     = r_dec;
  assign bus.neg     = r_neg;
  assign bus.ovf     = r_ovf;
  assign bus.lz_mask = w_lz;
  assign bus.busy    = (r_state == ST_CONV);
  assign bus.done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a default 24-bit/8-digit instance and a
// 16-bit/4-digit instance, checked every cycle against an arithmetic model
// plus directed vectors with literal expectations.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(24), .DIGITS(8)) ifa ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) ifb ();

  bin_to_bcd_seq #(.BIN_W(24), .DIGITS(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // uniform views of both instances
  logic        st_i   [2];
  logic        sgn_i  [2];
  logic [63:0] bin_i  [2];
  logic [63:0] dec_o  [2];
  logic [63:0] lz_o   [2];
  logic        neg_o  [2];
  logic        ovf_o  [2];
  logic        busy_o [2];
  logic        done_o [2];

  assign st_i[0]   = ifa.st;
  assign sgn_i[0]  = ifa.sgn;
  assign bin_i[0]  = 64'(ifa.BIN);
  assign dec_o[0]  = 64'(ifa.DEC);
  assign lz_o[0]   = 64'(ifa.lz_mask);
  assign neg_o[0]  = ifa.neg;
  assign ovf_o[0]  = ifa.ovf;
  assign busy_o[0] = ifa.busy;
  assign done_o[0] = ifa.done;
  assign st_i[1]   = ifb.st;
  assign sgn_i[1]  = ifb.sgn;
  assign bin_i[1]  = 64'(ifb.BIN);
  assign dec_o[1]  = 64'(ifb.DEC);
  assign lz_o[1]   = 64'(ifb.lz_mask);
  assign neg_o[1]  = ifb.neg;
  assign ovf_o[1]  = ifb.ovf;
  assign busy_o[1] = ifb.busy;
  assign done_o[1] = ifb.done;

  int BW [2] = '{24, 16};
  int DG [2] = '{8, 4};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result by plain arithmetic: magnitude, decimal digits by division,
  // latency = digit sum + digit count
  function automatic void model_conv(input int bw, input int dg, input logic [63:0] bin,
                                     input logic sgn, output logic [63:0] dec,
                                     output logic ng, output logic ov, output int lat);
    longint unsigned v, mag, lim;
    int d, s;
    v   = bin & ((64'd1 << bw) - 64'd1);
    ng  = sgn && bin[bw-1];
    mag = ng ? ((64'd1 << bw) - v) : v;
    lim = 1;
    for (int k = 0; k < dg; k++) lim = lim * 10;
    dec = '0;
    s   = 0;
    lat = 0;
    ov  = (mag >= lim);
    if (!ov) begin
      for (int k = 0; k < dg; k++) begin
        d   = int'(mag % 10);
        mag = mag / 10;
        dec = dec | (64'(d) << (4 * k));
        s   = s + d;
      end
      lat = s + dg;
    end
  endfunction

  function automatic logic [63:0] lz_of(input logic [63:0] dec, input int dg);
    logic [63:0] r;
    r = '0;
    for (int k = 1; k < dg; k++) begin
      if ((dec >> (4 * k)) == 64'd0) r[k] = 1'b1;
    end
    return r;
  endfunction

  // model: 0 idle, 1 converting, 2 done cycle
  int          m_phase [2];
  int          m_rem   [2];
  logic [63:0] m_dec   [2];
  logic [63:0] m_fin   [2];
  logic        m_neg   [2];
  logic        m_ovf   [2];
  int          done_cnt[2] = '{0, 0};

  always @(posedge clk) begin
    logic [63:0] t_dec;
    logic        t_ng, t_ov;
    int          t_lat;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] <= 0;
        m_dec[i]   <= '0;
        m_neg[i]   <= 1'b0;
        m_ovf[i]   <= 1'b0;
      end else begin
        case (m_phase[i])
          0: if (st_i[i]) begin
            model_conv(BW[i], DG[i], bin_i[i], sgn_i[i], t_dec, t_ng, t_ov, t_lat);
            m_neg[i]   <= t_ng;
            m_ovf[i]   <= t_ov;
            m_dec[i]   <= '0;
            m_fin[i]   <= t_dec;
            m_rem[i]   <= t_lat;
            m_phase[i] <= t_ov ? 2 : 1;
          end
          1: if (m_rem[i] == 1) begin
            m_phase[i] <= 2;
            m_dec[i]   <= m_fin[i];
          end else begin
            m_rem[i] <= m_rem[i] - 1;
          end
          default: m_phase[i] <= 0;
        endcase
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_o[i] === 1'b1) done_cnt[i]++;
      chk($sformatf("u%0d.busy", i), 64'(busy_o[i]), 64'(m_phase[i] == 1));
      chk($sformatf("u%0d.done", i), 64'(done_o[i]), 64'(m_phase[i] == 2));
      chk($sformatf("u%0d.neg", i),  64'(neg_o[i]),  64'(m_neg[i]));
      chk($sformatf("u%0d.ovf", i),  64'(ovf_o[i]),  64'(m_ovf[i]));
      if (m_phase[i] != 1) begin
        chk($sformatf("u%0d.DEC", i), dec_o[i], m_dec[i]);
        chk($sformatf("u%0d.lz", i),  lz_o[i],  lz_of(m_dec[i], DG[i]));
      end
    end
  end

  task automatic drive(input int i, input logic st, input logic sgn, input logic [63:0] bin);
    if (i == 0) begin
      ifa.st = st; ifa.sgn = sgn; ifa.BIN = bin[23:0];
    end else begin
      ifb.st = st; ifb.sgn = sgn; ifb.BIN = bin[15:0];
    end
  endtask

  task automatic set_st(input int i, input logic v);
    if (i == 0) ifa.st = v;
    else        ifb.st = v;
  endtask

  // One conversion with literal expectations; x_lat = edges after the start
  // edge until done is showing (0 for overflow). poke pulses st mid-conversion.
  task automatic run(input int i, input logic [63:0] bin, input logic sgn,
                     input logic [63:0] x_dec, input logic x_neg, input logic x_ovf,
                     input int x_lat, input logic [63:0] x_lz, input bit poke);
    int n, nbusy, dc0;
    bit seen;
    @(negedge clk);
    drive(i, 1'b1, sgn, bin);
    @(posedge clk);
    #1 set_st(i, 1'b0);
    n = 0; nbusy = 0; seen = 0;
    dc0 = done_cnt[i];
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) set_st(i, 1'b1);
      if (poke && n == 6) set_st(i, 1'b0);
      if (busy_o[i]) nbusy++;
      if (done_o[i]) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL u%0d.timeout bin=%0h: no done within 400 cycles", i, bin);
    end else begin
      chk($sformatf("u%0d.latency bin=%0h", i, bin), 64'(n - 1), 64'(x_lat));
      chk($sformatf("u%0d.busycyc bin=%0h", i, bin), 64'(nbusy), 64'(x_lat));
      chk($sformatf("u%0d.DEC bin=%0h", i, bin), dec_o[i], x_dec);
      chk($sformatf("u%0d.neg bin=%0h", i, bin), 64'(neg_o[i]), 64'(x_neg));
      chk($sformatf("u%0d.ovf bin=%0h", i, bin), 64'(ovf_o[i]), 64'(x_ovf));
      chk($sformatf("u%0d.lz bin=%0h", i, bin), lz_o[i], x_lz);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      chk($sformatf("u%0d.one_done", i), 64'(done_cnt[i] - dc0), 64'd1);
    end
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.DEC", dec_o[0], 64'd0);
    chk("rst.lz_a", lz_o[0], 64'hFE);
    chk("rst.lz_b", lz_o[1], 64'hE);
    chk("rst.busy", 64'(busy_o[0]), 64'd0);
    chk("rst.done", 64'(done_o[0]), 64'd0);
    chk("rst.neg_ovf", {62'd0, neg_o[0], ovf_o[0]}, 64'd0);

    run(0, 64'd12345678, 1'b0, 64'h12345678, 1'b0, 1'b0, 44, 64'h00, 1'b0);
    run(0, 64'hFFFFFF,   1'b0, 64'h16777215, 1'b0, 1'b0, 44, 64'h00, 1'b0);
    run(0, 64'hFFFFFF,   1'b1, 64'h00000001, 1'b1, 1'b0,  9, 64'hFE, 1'b0);
    run(0, 64'h800000,   1'b1, 64'h08388608, 1'b1, 1'b0, 49, 64'h80, 1'b0);
    run(0, 64'd0,        1'b0, 64'h00000000, 1'b0, 1'b0,  8, 64'hFE, 1'b0);
    run(1, 64'd10000,    1'b0, 64'h0000,     1'b0, 1'b1,  0, 64'hE,  1'b0);
    run(1, 64'd9999,     1'b0, 64'h9999,     1'b0, 1'b0, 40, 64'h0,  1'b0);
    run(1, 64'hFFFF,     1'b1, 64'h0001,     1'b1, 1'b0,  5, 64'hE,  1'b0);
    run(0, 64'd305,      1'b0, 64'h00000305, 1'b0, 1'b0, 16, 64'hF8, 1'b1);

    // reset ten edges into a conversion
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'd12345678);
    @(posedge clk);
    #1 set_st(0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dc = done_cnt[0];
    @(negedge clk);
    chk("midrst.busy", 64'(busy_o[0]), 64'd0);
    chk("midrst.DEC", dec_o[0], 64'd0);
    repeat (50) @(negedge clk);
    chk("midrst.no_done", 64'(done_cnt[0] - dc), 64'd0);
    run(0, 64'd12345678, 1'b0, 64'h12345678, 1'b0, 1'b0, 44, 64'h00, 1'b0);

    // st and rst on the same edge
    @(negedge clk);
    set_st(0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 begin set_st(0, 1'b0); rst = 1'b0; end
    dc = done_cnt[0];
    repeat (5) @(negedge clk);
    chk("strst.busy", 64'(busy_o[0]), 64'd0);
    chk("strst.no_done", 64'(done_cnt[0] - dc), 64'd0);
    chk("strst.DEC", dec_o[0], 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using successive subtraction of decimal weights, one subtraction per clock. It generalises the fixed 24-bit/8-digit converter to any input width and digit count, and adds:
- a start/busy/done handshake,
- optional two's-complement input,
- overflow detection,
- a leading-zero mask for display blanking.

It sits between binary datapaths (counters, frequency meters) and the seven-segment display drivers.

## Interface
- BIN_W, 24, input binary width (4..32)
- DIGITS, 8, number of BCD output digits (1..9)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st  in  1  start request; sampled every edge, honoured only when busy=0
- sgn  in  1  sampled with st; 1 = BIN is two's complement
- BIN  in  BIN_W  value to convert; sampled with st
- DEC  out  4*DIGITS  BCD result; digit k occupies DEC[4k+3:4k]; reset 0
- neg  out  1  result is negative; reset 0
- ovf  out  1  magnitude ≥ 10^DIGITS; reset 0
- lz_mask  out  DIGITS  bit k = 1 when digit k is a leading zero; bit 0 always 0; reset all-ones except bit 0
- busy  out  1  conversion in progress; reset 0
- done  out  1  one-cycle pulse, result valid; reset 0

## Operation
- States:
  - IDLE: outputs hold the last result.
  - CONV: conversion in progress.
  - DONE: done=1 for exactly one cycle, then back to IDLE.
- IDLE with st=1: the design captures the inputs on this edge.
  - neg = sgn & BIN[BIN_W-1].
  - Magnitude mag = neg ? -BIN : BIN, computed in BIN_W+1 bits so the most negative value converts correctly.
  - DEC, ovf are cleared; ptr = DIGITS-1.
  - If mag ≥ 10^DIGITS: ovf=1, DEC stays 0, next state is DONE. Otherwise next state is CONV.
- CONV, each edge, with dx = rest − W[ptr] and W[k] = 10^k:
  - dx ≥ 0: rest ← dx; digit[ptr] increments.
  - dx < 0 and ptr > 0: ptr decrements.
  - dx < 0 and ptr = 0: go to DONE.
- Width rules:
  - rest is BIN_W+1 bits.
  - Weights and dx are WT_W = clog2(10^DIGITS)+1 bits, zero-extended as needed.
  - The sign of dx is the compare result.
  - A digit never exceeds 9.
- busy = 1 exactly while in CONV.
- st while busy=1 or in DONE is ignored; no queuing.
- lz_mask is combinational from the registered DEC.
  - Bit k=1 iff digits DIGITS-1..k are all zero and k>0.
  - It is meaningful whenever busy=0.
- neg with magnitude 0 cannot occur, because the two's-complement −0 is 0.

## Timing
- Edge E0 samples st in IDLE. Conversion latency N = (sum of result digits) + DIGITS edges; done is high in the cycle after edge E0+N.
- Overflow: done is high in the cycle after E0 (N=1 counting E0); busy never asserts.
- DEC, neg, ovf are stable from the done cycle until the next accepted st edge. On that edge they clear to 0, with the new neg.
- DEC digits change only during CONV.
- rst has priority over st on the same edge.
- rst mid-conversion: on the next edge, state=IDLE and all outputs return to their reset values; the partial result is discarded.
- Back-to-back: st may be asserted in the cycle after done; it is accepted because the state is IDLE.

## Structure
- Package bcd_pkg:
  - state enum (IDLE, CONV, DONE);
  - constant function pow10(k);
  - constant function clog2;
  - derived widths WT_W, REST_W.
- Sub-module bcd_pow10_rom (parameter DIGITS, WT_W): combinational ptr → 10^ptr lookup built from pow10, so the weight mux is independent of the FSM.
- Top holds the FSM, rest, ptr, the digit registers and the lz_mask logic.

## Test plan
- Defaults, BIN=12345678, sgn=0 → DEC=32'h12345678, neg=0, ovf=0; done after 44 edges; busy high 44 cycles.
- Defaults, BIN=24'hFFFFFF, sgn=0 → DEC=32'h16777215, done after 44 edges. Same BIN with sgn=1 → neg=1, DEC=32'h00000001, done after 9 edges, lz_mask=8'hFE.
- Defaults, BIN=24'h800000, sgn=1 → neg=1, DEC=32'h08388608, lz_mask=8'h80. BIN=0 → DEC=0, done after 8 edges, lz_mask=8'hFE.
- BIN_W=16, DIGITS=4:
  - BIN=10000 → ovf=1, DEC=0, done one edge after st, busy never high.
  - BIN=9999 → DEC=16'h9999, done after 40 edges.
- Defaults, BIN=305 → DEC=32'h00000305, lz_mask=8'hF8. A second st pulsed during busy is ignored: the result is unchanged and exactly one done pulse occurs.
- rst asserted 10 edges into a conversion of 12345678 → next edge busy=0, DEC=0, done never pulses. A fresh st then converts correctly. st and rst together → IDLE, no conversion.
